// File: rtl/ws2812b_seq_pkg.sv
// Register map, FSM encoding and sizing shared by the WS2812B frame sequencer.
package ws2812b_seq_pkg;

   localparam int MAX_PIXELS = 16;

   localparam logic [3:0] ADDR_CTRL    = 4'h0;
   localparam logic [3:0] ADDR_LEN     = 4'h1;
   localparam logic [3:0] ADDR_PAL_IDX = 4'h2;
   localparam logic [3:0] ADDR_PAL_G   = 4'h3;
   localparam logic [3:0] ADDR_PAL_R   = 4'h4;
   localparam logic [3:0] ADDR_PAL_B   = 4'h5;
   localparam logic [3:0] ADDR_PIX_IDX = 4'h7;
   localparam logic [3:0] ADDR_PIX0    = 4'h8;
   localparam logic [3:0] ADDR_PIX1    = 4'h9;
   localparam logic [3:0] ADDR_PIX2    = 4'hA;
   localparam logic [3:0] ADDR_PIX3    = 4'hB;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/ws2812b_seq_palette.sv
// Four-entry GRB palette: byte-lane writes through PAL_IDX, register readback and pixel lookup.
module ws2812b_seq_palette
   import ws2812b_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [3:0]  addr,
   input  logic [7:0]  wr_data,
   input  logic [1:0]  sel_idx,
   output logic [7:0]  rd_data,
   input  logic [1:0]  lookup_idx,
   output logic [23:0] lookup_color
);

   logic [3:0][23:0] pal;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pal <= '0;
      end else if (wr_en) begin
         case (addr)
            ADDR_PAL_G: pal[sel_idx][23:16] <= wr_data;
            ADDR_PAL_R: pal[sel_idx][15:8]  <= wr_data;
            ADDR_PAL_B: pal[sel_idx][7:0]   <= wr_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (addr)
         ADDR_PAL_G: rd_data = pal[sel_idx][23:16];
         ADDR_PAL_R: rd_data = pal[sel_idx][15:8];
         ADDR_PAL_B: rd_data = pal[sel_idx][7:0];
         default:    rd_data = 8'h00;
      endcase
   end

   assign lookup_color = pal[lookup_idx];

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Register-programmed frame sequencer feeding palette-indexed GRB pixels to a WS2812B serial core.
module ws2812b_frame_sequencer
   import ws2812b_seq_pkg::*;
#(
   parameter int MAX_PIXELS = ws2812b_seq_pkg::MAX_PIXELS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  address,
   input  logic        data_write,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic [23:0] px_data,
   output logic        px_valid,
   output logic        px_latch,
   input  logic        px_ready
);

   localparam logic [7:0] LEN_LIMIT = 8'(MAX_PIXELS);

   seq_state_t  state, state_nxt;
   logic [3:0]  idx, idx_nxt;
   logic [3:0]  last_idx;
   logic [4:0]  len_reg;
   logic [4:0]  len_wr;
   logic [1:0]  pal_idx;
   logic [31:0] pix_mem;
   logic        repeat_en;
   logic        abort_pend;
   logic        busy;
   logic        ctrl_wr;
   logic        start_frame;
   logic        load_px;
   logic        abort_exit;
   logic [1:0]  pal_code;
   logic [23:0] pal_color;
   logic [7:0]  pal_rd;

   assign busy     = (state != IDLE);
   assign px_valid = (state == ISSUE);
   assign px_latch = px_valid && (idx == last_idx);
   assign ctrl_wr  = data_write && (address == ADDR_CTRL);
   assign len_wr   = (data_in > LEN_LIMIT) ? LEN_LIMIT[4:0] : data_in[4:0];
   // Palette code of the pixel about to enter ISSUE, so px_data is frozen on entry.
   assign pal_code = pix_mem[{idx_nxt, 1'b0} +: 2];

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      start_frame = 1'b0;
      load_px     = 1'b0;
      abort_exit  = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_wr && data_in[0] && (len_reg != 5'd0)) begin
               state_nxt   = ISSUE;
               idx_nxt     = 4'd0;
               start_frame = 1'b1;
               load_px     = 1'b1;
            end
         end
         ISSUE: begin
            if (!px_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (px_ready) begin
               if (abort_pend) begin
                  state_nxt  = IDLE;
                  abort_exit = 1'b1;
               end else if (idx != last_idx) begin
                  state_nxt = ISSUE;
                  idx_nxt   = idx + 4'd1;
                  load_px   = 1'b1;
               end else if (repeat_en) begin
                  state_nxt = ISSUE;
                  idx_nxt   = 4'd0;
                  load_px   = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= 4'd0;
         last_idx   <= 4'd0;
         px_data    <= 24'd0;
         len_reg    <= 5'd0;
         pal_idx    <= 2'd0;
         pix_mem    <= 32'd0;
         repeat_en  <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (start_frame) last_idx <= 4'(len_reg - 5'd1);
         if (load_px) px_data <= pal_color;
         if (abort_exit) begin
            abort_pend <= 1'b0;
            repeat_en  <= 1'b0;
         end
         if (data_write) begin
            case (address)
               ADDR_CTRL: begin
                  repeat_en <= data_in[1];
                  if (data_in[2] && busy) abort_pend <= 1'b1;
               end
               ADDR_LEN:     len_reg <= len_wr;
               ADDR_PAL_IDX: pal_idx <= data_in[1:0];
               ADDR_PIX0, ADDR_PIX1, ADDR_PIX2, ADDR_PIX3:
                  pix_mem[{address[1:0], 3'b000} +: 8] <= data_in;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      data_out = 8'h00;
      case (address)
         ADDR_CTRL:    data_out = {5'b0, repeat_en, abort_pend, busy};
         ADDR_LEN:     data_out = {3'b0, len_reg};
         ADDR_PAL_IDX: data_out = {6'b0, pal_idx};
         ADDR_PAL_G, ADDR_PAL_R, ADDR_PAL_B:
                       data_out = pal_rd;
         ADDR_PIX_IDX: data_out = {4'b0, idx};
         ADDR_PIX0, ADDR_PIX1, ADDR_PIX2, ADDR_PIX3:
                       data_out = pix_mem[{address[1:0], 3'b000} +: 8];
         default:      data_out = 8'h00;
      endcase
   end

   ws2812b_seq_palette u_palette (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (data_write),
      .addr         (address),
      .wr_data      (data_in),
      .sel_idx      (pal_idx),
      .rd_data      (pal_rd),
      .lookup_idx   (pal_code),
      .lookup_color (pal_color)
   );

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected pixels, a core model accepts and checks them.
`timescale 1ns/1ps
module tb_ws2812b_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  address = 4'h0;
   logic        data_write = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  data_out;
   logic [23:0] px_data;
   logic        px_valid;
   logic        px_latch;
   logic        px_ready = 1'b1;

   ws2812b_frame_sequencer #(.MAX_PIXELS(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out),
      .px_data    (px_data),
      .px_valid   (px_valid),
      .px_latch   (px_latch),
      .px_ready   (px_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] color;
      logic        latch;
   } pix_exp_t;

   pix_exp_t    exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          issue_cnt = 0;
   int          accept_delay = 0;
   int          hold_cycles = 2;
   logic [23:0] m_pal[4];
   logic [7:0]  m_pix[4];
   int          m_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_pal[k] = 24'h0;
         m_pix[k] = 8'h0;
      end
      m_len = 0;
   endtask

   // Pixel i uses the 2-bit code at bit 2*(i mod 4) of pixel byte i/4.
   function automatic logic [23:0] model_color(input int i);
      int code;
      code = int'((m_pix[i / 4] >> (2 * (i % 4))) & 8'h3);
      return m_pal[code];
   endfunction

   task automatic push_frame(input int len, input int count, input bit with_latch);
      for (int i = 0; i < count; i++)
         exp_q.push_back('{color: model_color(i), latch: with_latch && (i == len - 1)});
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a;
      data_in = d;
      data_write = 1'b1;
      @(negedge clk);
      data_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] v);
      @(negedge clk);
      data_write = 1'b0;
      address = a;
      #1;
      v = data_out;
   endtask

   task automatic set_pal(input int k, input logic [23:0] c);
      wr(4'h2, 8'(k));
      wr(4'h3, c[23:16]);
      wr(4'h4, c[15:8]);
      wr(4'h5, c[7:0]);
      m_pal[k] = c;
   endtask

   task automatic set_pix(input int k, input logic [7:0] v);
      wr(4'(8 + k), v);
      m_pix[k] = v;
   endtask

   task automatic set_len(input int v);
      wr(4'h1, 8'(v));
      m_len = (v > 16) ? 16 : v;
   endtask

   task automatic wait_issue(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (issue_cnt >= target) return;
      end
      check("issue_timeout", 32'(issue_cnt), 32'(target));
   endtask

   task automatic wait_idle(input int budget);
      logic [7:0] v;
      for (int i = 0; i < budget; i++) begin
         rd(4'h0, v);
         if (v[0] == 1'b0) return;
      end
      check("busy_timeout", 32'(v[0]), 32'd0);
   endtask

   // Core model: accepts a pixel after accept_delay cycles, then holds ready low.
   initial begin : core_model
      logic [23:0] seen;
      pix_exp_t    e;
      forever begin
         @(negedge clk);
         if (rst_n && px_valid && px_ready) begin
            issue_cnt++;
            seen = px_data;
            for (int k = 0; k < accept_delay; k++) begin
               @(negedge clk);
               check("px_hold_stable", {7'b0, px_valid, px_data}, {8'h01, seen});
            end
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pixel: got data 0x%0h latch %0b, expected no pixel", px_data, px_latch);
            end else begin
               e = exp_q.pop_front();
               check("px_data", 32'(px_data), 32'(e.color));
               check("px_latch", 32'(px_latch), 32'(e.latch));
            end
            px_ready = 1'b0;
            repeat (hold_cycles) @(negedge clk);
            px_ready = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [7:0] v;
      int         base;
      int         len;
      model_reset();

      repeat (3) @(negedge clk);
      check("rst_px_valid", 32'(px_valid), 32'd0);
      check("rst_px_latch", 32'(px_latch), 32'd0);
      check("rst_px_data", 32'(px_data), 32'd0);
      rst_n = 1'b1;
      rd(4'h0, v); check("rst_ctrl", 32'(v), 32'd0);
      rd(4'h1, v); check("rst_len", 32'(v), 32'd0);
      for (int a = 3; a <= 5; a++) begin
         rd(4'(a), v); check("rst_palette", 32'(v), 32'd0);
      end
      for (int a = 8; a <= 11; a++) begin
         rd(4'(a), v); check("rst_pixbyte", 32'(v), 32'd0);
      end
      wr(4'h6, 8'hFF);
      rd(4'h6, v); check("unmapped_read", 32'(v), 32'd0);

      set_len(20);
      rd(4'h1, v); check("len_clamp", 32'(v), 32'd16);
      set_len(5);
      rd(4'h1, v); check("len_plain", 32'(v), 32'd5);

      // Basic frame with a slow core
      accept_delay = 0;
      hold_cycles = 10;
      set_pal(0, 24'h00FF00);
      set_pal(1, 24'h0000FF);
      set_pix(0, 8'h04);
      set_len(3);
      exp_q.push_back('{color: 24'h00FF00, latch: 1'b0});
      exp_q.push_back('{color: 24'h0000FF, latch: 1'b0});
      exp_q.push_back('{color: 24'h00FF00, latch: 1'b1});
      base = issue_cnt;
      wr(4'h0, 8'h01);
      wait_idle(300);
      check("basic_count", 32'(issue_cnt - base), 32'd3);
      check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

      // Start with LEN=0 does nothing
      set_len(0);
      base = issue_cnt;
      wr(4'h0, 8'h01);
      repeat (100) @(negedge clk);
      check("len0_no_pixel", 32'(issue_cnt), 32'(base));
      check("len0_latch", 32'(px_latch), 32'd0);
      rd(4'h0, v); check("len0_busy", 32'(v), 32'd0);

      // Repeat two frames, repeat cleared during the second
      accept_delay = 1;
      hold_cycles = 3;
      set_len(2);
      base = issue_cnt;
      push_frame(2, 2, 1'b1);
      push_frame(2, 2, 1'b1);
      wr(4'h0, 8'h03);
      wait_issue(base + 3, 300);
      wr(4'h0, 8'h00);
      wait_idle(300);
      repeat (30) @(negedge clk);
      check("repeat_count", 32'(issue_cnt - base), 32'd4);
      check("repeat_queue_empty", 32'(exp_q.size()), 32'd0);
      rd(4'h0, v); check("repeat_ctrl_after", 32'(v), 32'd0);

      // Abort during pixel 5
      for (int k = 0; k < 4; k++) set_pal(k, 24'($urandom));
      for (int k = 0; k < 4; k++) set_pix(k, 8'($urandom));
      accept_delay = 4;
      hold_cycles = 3;
      set_len(16);
      base = issue_cnt;
      push_frame(16, 6, 1'b0);
      wr(4'h0, 8'h01);
      wait_issue(base + 6, 600);
      wr(4'h0, 8'h04);
      rd(4'h0, v); check("abort_pend_set", 32'(v), 32'h03);
      wait_idle(300);
      repeat (40) @(negedge clk);
      rd(4'h0, v); check("abort_ctrl_after", 32'(v), 32'd0);
      check("abort_count", 32'(issue_cnt - base), 32'd6);
      check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
      wr(4'h0, 8'h04);
      rd(4'h0, v); check("abort_idle_ignored", 32'(v), 32'd0);

      // Live palette rewrite while pixel 2 is in ISSUE
      set_pal(0, 24'h123456);
      set_pal(1, 24'hA5A5A5);
      set_pal(2, 24'h0F0F0F);
      set_pix(0, 8'h09);
      set_len(4);
      wr(4'h2, 8'h00);
      accept_delay = 6;
      hold_cycles = 2;
      base = issue_cnt;
      exp_q.push_back('{color: 24'hA5A5A5, latch: 1'b0});
      exp_q.push_back('{color: 24'h0F0F0F, latch: 1'b0});
      exp_q.push_back('{color: 24'h123456, latch: 1'b0});
      exp_q.push_back('{color: 24'hFFFFFF, latch: 1'b1});
      wr(4'h0, 8'h01);
      wait_issue(base + 3, 300);
      wr(4'h3, 8'hFF);
      wr(4'h4, 8'hFF);
      wr(4'h5, 8'hFF);
      m_pal[0] = 24'hFFFFFF;
      wait_idle(300);
      check("live_queue_empty", 32'(exp_q.size()), 32'd0);

      // Randomized frames with ignored restart and deferred LEN change
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 4; k++) set_pal(k, 24'($urandom));
         for (int k = 0; k < 4; k++) set_pix(k, 8'($urandom));
         len = int'($urandom_range(3, 16));
         set_len(len);
         accept_delay = int'($urandom_range(0, 3));
         hold_cycles = int'($urandom_range(2, 6));
         base = issue_cnt;
         push_frame(len, len, 1'b1);
         wr(4'h0, 8'h01);
         wait_issue(base + 1, 100);
         wr(4'h0, 8'h01);
         set_len(int'($urandom_range(1, 16)));
         wait_idle(2000);
         repeat (10) @(negedge clk);
         check("rand_count", 32'(issue_cnt - base), 32'(len));
         check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      end

      // Reset while waiting on the core
      accept_delay = 0;
      hold_cycles = 8;
      set_len(8);
      base = issue_cnt;
      push_frame(8, 8, 1'b1);
      wr(4'h0, 8'h01);
      wait_issue(base + 2, 200);
      @(negedge clk);
      check("wait_state_valid", 32'(px_valid), 32'd0);
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      check("midrst_px_valid", 32'(px_valid), 32'd0);
      check("midrst_px_latch", 32'(px_latch), 32'd0);
      check("midrst_px_data", 32'(px_data), 32'd0);
      rst_n = 1'b1;
      rd(4'h0, v); check("midrst_ctrl", 32'(v), 32'd0);
      rd(4'h1, v); check("midrst_len", 32'(v), 32'd0);
      for (int a = 3; a <= 5; a++) begin
         rd(4'(a), v); check("midrst_palette", 32'(v), 32'd0);
      end
      repeat (40) @(negedge clk);
      check("midrst_no_pixel", 32'(issue_cnt), 32'(base + 2));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
